// File: rtl/bp_cce_pkg.sv
// bp_cce_pkg: serializer state encoding, default block geometry and memory message field widths
package bp_cce_pkg;
  localparam int cce_mem_msg_type_width_lp = 2;
  localparam int beats_lp = 8;
  localparam int block_offset_lp = 6;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    RD_RESP = 3'd5
  } bp_me_mem_serializer_state_e;
endpackage

// File: rtl/bp_me_block_sipo.sv
// bp_me_block_sipo: collects in-order dword beats (v_i/data_i) into a block (data_o); clear_i restarts, last_o marks the final beat, full_o holds after it
module bp_me_block_sipo
  #(parameter int block_width_p = 512
  , parameter int dword_width_p = 64
  , localparam int beats_lp = block_width_p / dword_width_p
  , localparam int lg_beats_lp = $clog2(beats_lp))
  (input  logic                     clk_i
  , input  logic                     reset_n_i
  , input  logic                     clear_i
  , input  logic                     v_i
  , input  logic [dword_width_p-1:0] data_i
  , output logic [block_width_p-1:0] data_o
  , output logic                     last_o
  , output logic                     full_o);

  logic [lg_beats_lp-1:0] rcv_cnt, rcv_nxt;
  logic carry;

  assign {carry, rcv_nxt} = {1'b0, rcv_cnt} + (lg_beats_lp+1)'(1);
  assign last_o = v_i & carry;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      rcv_cnt <= '0;
      full_o <= 1'b0;
    end else if (clear_i) begin
      rcv_cnt <= '0;
      full_o <= 1'b0;
    end else if (v_i) begin
      rcv_cnt <= rcv_nxt;
      full_o <= full_o | carry;
    end

  for (genvar i = 0; i < beats_lp; i++) begin : g_slot
    logic [dword_width_p-1:0] slot_r;
    logic we;
    assign we = v_i & (rcv_cnt == lg_beats_lp'(i));
    assign data_o[i*dword_width_p +: dword_width_p] = slot_r;
    always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) slot_r <= '0;
      else if (we) slot_r <= data_i;
  end

endmodule

// File: rtl/bp_me_mem_serializer.sv
// bp_me_mem_serializer: turns CCE block commands (mem_cmd/mem_data_cmd) into dword beats on the dram bus and returns mem_resp/mem_data_resp
module bp_me_mem_serializer
  import bp_cce_pkg::*;
  #(parameter int paddr_width_p = 39
  , parameter int cce_block_width_p = 8 << block_offset_lp
  , parameter int dword_width_p = cce_block_width_p / beats_lp
  , parameter int num_lce_p = 2
  , parameter int lce_assoc_p = 8
  , localparam int lce_id_width_lp = num_lce_p > 1 ? $clog2(num_lce_p) : 1
  , localparam int way_id_width_lp = $clog2(lce_assoc_p)
  , localparam int addr_lsb_lp = lce_id_width_lp + way_id_width_lp
  , localparam int hdr_width_lp = cce_mem_msg_type_width_lp + paddr_width_p + addr_lsb_lp
  , localparam int cce_mem_cmd_width_lp = hdr_width_lp
  , localparam int cce_mem_data_cmd_width_lp = hdr_width_lp + cce_block_width_p
  , localparam int mem_cce_resp_width_lp = hdr_width_lp
  , localparam int mem_cce_data_resp_width_lp = hdr_width_lp + cce_block_width_p)
  (input  logic                                  clk_i
  , input  logic                                  reset_n_i
  , input  logic [cce_mem_cmd_width_lp-1:0]       mem_cmd_i
  , input  logic                                  mem_cmd_v_i
  , output logic                                  mem_cmd_yumi_o
  , input  logic [cce_mem_data_cmd_width_lp-1:0]  mem_data_cmd_i
  , input  logic                                  mem_data_cmd_v_i
  , output logic                                  mem_data_cmd_yumi_o
  , output logic [mem_cce_resp_width_lp-1:0]      mem_resp_o
  , output logic                                  mem_resp_v_o
  , input  logic                                  mem_resp_ready_i
  , output logic [mem_cce_data_resp_width_lp-1:0] mem_data_resp_o
  , output logic                                  mem_data_resp_v_o
  , input  logic                                  mem_data_resp_ready_i
  , output logic                                  dram_v_o
  , output logic                                  dram_w_o
  , output logic [paddr_width_p-1:0]              dram_addr_o
  , output logic [dword_width_p-1:0]              dram_data_o
  , input  logic                                  dram_ready_i
  , input  logic                                  dram_data_v_i
  , input  logic [dword_width_p-1:0]              dram_data_i);

  localparam int lg_beats_lp = $clog2(cce_block_width_p / dword_width_p);
  localparam int dw_off_lp = $clog2(dword_width_p / 8);
  localparam int blk_off_lp = lg_beats_lp + dw_off_lp;

  bp_me_mem_serializer_state_e state_r, state_nxt;
  logic [hdr_width_lp-1:0] hdr_r;
  logic [cce_block_width_p-1:0] data_r, rd_block;
  logic [lg_beats_lp-1:0] req_cnt, req_nxt;
  logic req_last, idle, fire, rd_v, rd_done, sipo_last, sipo_full;

  // yumi stays low while reset is held even though the state already reads IDLE
  assign idle = (state_r == IDLE) & reset_n_i;
  assign mem_data_cmd_yumi_o = mem_data_cmd_v_i & idle;
  assign mem_cmd_yumi_o = mem_cmd_v_i & ~mem_data_cmd_v_i & idle;
  assign dram_v_o = (state_r == WR_REQ) | (state_r == RD_REQ);
  assign dram_w_o = state_r == WR_REQ;
  assign fire = dram_v_o & dram_ready_i;
  // carry out of the beat counter marks the last beat so the counter can wrap freely
  assign {req_last, req_nxt} = {1'b0, req_cnt} + (lg_beats_lp+1)'(1);
  assign dram_addr_o = dram_v_o ? {hdr_r[addr_lsb_lp+blk_off_lp +: paddr_width_p-blk_off_lp], req_cnt, {dw_off_lp{1'b0}}} : '0;
  assign dram_data_o = dram_w_o ? data_r[req_cnt*dword_width_p +: dword_width_p] : '0;
  assign rd_v = dram_data_v_i & ((state_r == RD_REQ) | (state_r == RD_WAIT));
  assign rd_done = sipo_full | sipo_last;
  assign mem_resp_v_o = state_r == WR_RESP;
  assign mem_resp_o = mem_resp_v_o ? hdr_r : '0;
  assign mem_data_resp_v_o = state_r == RD_RESP;
  assign mem_data_resp_o = mem_data_resp_v_o ? {hdr_r, rd_block} : '0;

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    state_nxt = mem_data_cmd_yumi_o ? WR_REQ : mem_cmd_yumi_o ? RD_REQ : IDLE;
      WR_REQ:  state_nxt = (fire & req_last) ? WR_RESP : WR_REQ;
      WR_RESP: state_nxt = mem_resp_ready_i ? IDLE : WR_RESP;
      RD_REQ:  state_nxt = !(fire & req_last) ? RD_REQ : rd_done ? RD_RESP : RD_WAIT;
      RD_WAIT: state_nxt = rd_done ? RD_RESP : RD_WAIT;
      RD_RESP: state_nxt = mem_data_resp_ready_i ? IDLE : RD_RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r <= IDLE;
      req_cnt <= '0;
      hdr_r <= '0;
      data_r <= '0;
    end else begin
      if (mem_data_cmd_yumi_o) begin
        hdr_r <= mem_data_cmd_i[cce_block_width_p +: hdr_width_lp];
        data_r <= mem_data_cmd_i[cce_block_width_p-1:0];
      end else if (mem_cmd_yumi_o) hdr_r <= mem_cmd_i;
      if (state_r == IDLE) req_cnt <= '0;
      else if (fire) req_cnt <= req_nxt;
      state_r <= state_nxt;
    end

  bp_me_block_sipo #(.block_width_p(cce_block_width_p), .dword_width_p(dword_width_p)) sipo
    (.clk_i(clk_i)
    , .reset_n_i(reset_n_i)
    , .clear_i(mem_cmd_yumi_o)
    , .v_i(rd_v)
    , .data_i(dram_data_i)
    , .data_o(rd_block)
    , .last_o(sipo_last)
    , .full_o(sipo_full));

  stray_beat: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    dram_data_v_i |-> (state_r == RD_REQ || state_r == RD_WAIT));

endmodule
